enc8to3_scan: RTL and testbench

- Sequential 8-to-3 encoder. It is the inverse of the team's 3-to-8 decoders.
- It accepts an 8-bit request vector (one-hot or multi-hot) over a valid/ready handshake and emits, one per handshake, the 3-bit index of every set bit in priority order.
- It sits between request-collecting logic and any consumer that needs binary indices, e.g. feeding the 3-to-8 decoders back.

---
 rtl/enc8to3_scan.sv | 87 ++++++++
 tb/tb_enc8to3_scan.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/enc8to3_scan.sv
// enc8to3_scan: sequential 8-to-3 encoder. Accepts a (multi-hot) request vector over a
// valid/ready handshake and emits the 3-bit index of every set bit, one per out handshake,
// in priority order selected by LSB_FIRST.
module enc8to3_scan #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [2:0] out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       zero_flag
);

  typedef enum logic {StIdle, StEmit} state_t;

  state_t     state;
  logic [7:0] pending;
  logic [2:0] head_idx;
  logic       head_last;
  logic       out_fire;
  logic       in_fire;

  // Index of the highest-priority set bit; the last match in the loop wins.
  function automatic logic [2:0] pick(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    if (LSB_FIRST) begin
      for (int i = 7; i >= 0; i--) begin
        if (v[i]) idx = 3'(i);
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (v[i]) idx = 3'(i);
      end
    end
    return idx;
  endfunction

  // Outputs are a pure decode of the state and pending registers.
  always_comb begin
    head_idx  = pick(pending);
    // Exactly one bit set: non-zero and clearing the lowest set bit leaves nothing.
    head_last = (pending != 8'd0) && ((pending & (pending - 8'd1)) == 8'd0);
    in_ready  = (state == StIdle);
    out_valid = (state == StEmit);
    out       = (state == StEmit) ? head_idx : 3'd0;
    out_last  = (state == StEmit) && head_last;
    in_fire   = in_valid && in_ready;
    out_fire  = out_valid && out_ready;
  end

  // FSM, pending vector and zero-vector pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      pending   <= 8'd0;
      zero_flag <= 1'b0;
    end else begin
      zero_flag <= in_fire && (in == 8'd0);
      unique case (state)
        StIdle: begin
          if (in_fire && (in != 8'd0)) begin
            pending <= in;
            state   <= StEmit;
          end
        end
        StEmit: begin
          if (out_fire) begin
            // Only the presented bit is retired, so nothing is skipped or repeated.
            pending <= pending & ~(8'd1 << head_idx);
            if (head_last) state <= StIdle;
          end
        end
        default: begin
          state   <= StIdle;
          pending <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_enc8to3_scan.sv
// Directed bench for enc8to3_scan: one LSB-first and one MSB-first instance share stimulus.
module tb_enc8to3_scan;

  logic       clk;
  logic       rst;
  logic [7:0] in;
  logic       in_valid;
  logic       out_ready;

  logic       in_ready_l, out_valid_l, out_last_l, zero_flag_l;
  logic [2:0] out_l;
  logic       in_ready_m, out_valid_m, out_last_m, zero_flag_m;
  logic [2:0] out_m;

  int n_checks;
  int n_fail;

  enc8to3_scan #(.LSB_FIRST(1'b1)) dut_lsb (
    .clk       (clk),
    .rst       (rst),
    .in        (in),
    .in_valid  (in_valid),
    .in_ready  (in_ready_l),
    .out       (out_l),
    .out_valid (out_valid_l),
    .out_ready (out_ready),
    .out_last  (out_last_l),
    .zero_flag (zero_flag_l)
  );

  enc8to3_scan #(.LSB_FIRST(1'b0)) dut_msb (
    .clk       (clk),
    .rst       (rst),
    .in        (in),
    .in_valid  (in_valid),
    .in_ready  (in_ready_m),
    .out       (out_m),
    .out_valid (out_valid_m),
    .out_ready (out_ready),
    .out_last  (out_last_m),
    .zero_flag (zero_flag_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in = 8'd0; in_valid = 1'b0; out_ready = 1'b0;
    tick(); tick();
    n_checks++;
    if ({out_valid_l, out_l, out_last_l, zero_flag_l} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b out=%0d last=%b zf=%b, want all 0",
               out_valid_l, out_l, out_last_l, zero_flag_l);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready_l !== 1'b1 || in_ready_m !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b/%b, want 1/1", in_ready_l, in_ready_m);
    end
  endtask

  task automatic test_single();
    in = 8'b0010_0000; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if ({out_valid_l, out_l, out_last_l, in_ready_l} !== {1'b1, 3'd5, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL single_emit: got valid=%b out=%0d last=%b rdy=%b, want 1 5 1 0",
               out_valid_l, out_l, out_last_l, in_ready_l);
    end
    n_checks++;
    if (out_m !== 3'd5 || out_last_m !== 1'b1) begin
      n_fail++;
      $display("FAIL single_emit_msb: got out=%0d last=%b, want 5 1", out_m, out_last_m);
    end
    tick();
    n_checks++;
    if (out_valid_l !== 1'b0 || in_ready_l !== 1'b1) begin
      n_fail++;
      $display("FAIL single_done: got valid=%b rdy=%b, want 0 1", out_valid_l, in_ready_l);
    end
  endtask

  task automatic test_sequence();
    logic [2:0] exp_l [3];
    logic [2:0] exp_m [3];
    exp_l = '{3'd1, 3'd4, 3'd7};
    exp_m = '{3'd7, 3'd4, 3'd1};
    in = 8'b1001_0010; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (out_valid_l !== 1'b1 || out_l !== exp_l[i] || out_last_l !== (i == 2)) begin
        n_fail++;
        $display("FAIL seq_lsb[%0d]: got valid=%b out=%0d last=%b, want 1 %0d %b",
                 i, out_valid_l, out_l, out_last_l, exp_l[i], (i == 2));
      end
      n_checks++;
      if (out_valid_m !== 1'b1 || out_m !== exp_m[i] || out_last_m !== (i == 2)) begin
        n_fail++;
        $display("FAIL seq_msb[%0d]: got valid=%b out=%0d last=%b, want 1 %0d %b",
                 i, out_valid_m, out_m, out_last_m, exp_m[i], (i == 2));
      end
      tick();
    end
    n_checks++;
    if (out_valid_l !== 1'b0 || out_valid_m !== 1'b0) begin
      n_fail++;
      $display("FAIL seq_end: got valid=%b/%b, want 0/0", out_valid_l, out_valid_m);
    end
  endtask

  task automatic test_stall();
    logic [2:0] exp_l [3];
    logic [2:0] exp_m [3];
    logic       pat [6];
    int         idx;
    exp_l = '{3'd1, 3'd4, 3'd7};
    exp_m = '{3'd7, 3'd4, 3'd1};
    pat   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    idx   = 0;
    in = 8'b1001_0010; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      out_ready = pat[c];
      n_checks++;
      if (out_valid_l !== 1'b1 || out_l !== exp_l[idx] || in_ready_l !== 1'b0 ||
          out_last_l !== (idx == 2)) begin
        n_fail++;
        $display("FAIL stall_lsb[%0d]: got valid=%b out=%0d last=%b rdy=%b, want 1 %0d %b 0",
                 c, out_valid_l, out_l, out_last_l, in_ready_l, exp_l[idx], (idx == 2));
      end
      n_checks++;
      if (out_m !== exp_m[idx] || in_ready_m !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_msb[%0d]: got out=%0d rdy=%b, want %0d 0",
                 c, out_m, in_ready_m, exp_m[idx]);
      end
      tick();
      if (pat[c]) idx++;
    end
    n_checks++;
    if (out_valid_l !== 1'b0 || in_ready_l !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_end: got valid=%b rdy=%b, want 0 1", out_valid_l, in_ready_l);
    end
  endtask

  task automatic test_zero();
    in = 8'h00; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (zero_flag_l !== 1'b1 || out_valid_l !== 1'b0 || in_ready_l !== 1'b1) begin
      n_fail++;
      $display("FAIL zero_pulse: got zf=%b valid=%b rdy=%b, want 1 0 1",
               zero_flag_l, out_valid_l, in_ready_l);
    end
    tick();
    n_checks++;
    if (zero_flag_l !== 1'b0 || out_valid_l !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_clear: got zf=%b valid=%b, want 0 0", zero_flag_l, out_valid_l);
    end
  endtask

  task automatic test_back_to_back();
    in = 8'hFF; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    // Second vector offered for the whole EMIT phase.
    in = 8'h03;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (out_valid_l !== 1'b1 || out_l !== 3'(i) || in_ready_l !== 1'b0 ||
          out_last_l !== (i == 7)) begin
        n_fail++;
        $display("FAIL ff_lsb[%0d]: got valid=%b out=%0d last=%b rdy=%b, want 1 %0d %b 0",
                 i, out_valid_l, out_l, out_last_l, in_ready_l, i, (i == 7));
      end
      n_checks++;
      if (out_m !== 3'(7 - i)) begin
        n_fail++;
        $display("FAIL ff_msb[%0d]: got out=%0d, want %0d", i, out_m, 7 - i);
      end
      tick();
    end
    n_checks++;
    if (out_valid_l !== 1'b0 || in_ready_l !== 1'b1) begin
      n_fail++;
      $display("FAIL ff_gap: got valid=%b rdy=%b, want 0 1", out_valid_l, in_ready_l);
    end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (out_valid_l !== 1'b1 || out_l !== 3'd0 || out_last_l !== 1'b0 || out_m !== 3'd1) begin
      n_fail++;
      $display("FAIL b2b_first: got valid=%b out=%0d last=%b msb=%0d, want 1 0 0 1",
               out_valid_l, out_l, out_last_l, out_m);
    end
    tick();
    n_checks++;
    if (out_l !== 3'd1 || out_last_l !== 1'b1 || out_m !== 3'd0) begin
      n_fail++;
      $display("FAIL b2b_second: got out=%0d last=%b msb=%0d, want 1 1 0",
               out_l, out_last_l, out_m);
    end
    tick();
    n_checks++;
    if (out_valid_l !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end: got valid=%b, want 0", out_valid_l);
    end
  endtask

  task automatic test_reset_mid_emit();
    in = 8'b1001_0010; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (out_l !== 3'd4 || out_valid_l !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre: got out=%0d valid=%b, want 4 1", out_l, out_valid_l);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid_l !== 1'b0 || out_l !== 3'd0 || out_last_l !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async: got valid=%b out=%0d last=%b, want 0 0 0",
               out_valid_l, out_l, out_last_l);
    end
    tick();
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready_l !== 1'b1 || out_valid_l !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_release: got rdy=%b valid=%b, want 1 0", in_ready_l, out_valid_l);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (out_valid_l !== 1'b0 || out_valid_m !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_quiet[%0d]: got valid=%b/%b, want 0/0", i, out_valid_l, out_valid_m);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single();
    test_sequence();
    test_stall();
    test_zero();
    test_back_to_back();
    test_reset_mid_emit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
